// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode of every base-ISA
// immediate format, captured into a 2-entry output FIFO with a saturating illegal counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_SHAMT = 3'd2;
  localparam logic [2:0] FMT_S     = 3'd3;
  localparam logic [2:0] FMT_B     = 3'd4;
  localparam logic [2:0] FMT_U     = 3'd5;
  localparam logic [2:0] FMT_J     = 3'd6;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh5, imm_sh6;
  logic [2:0]       funct3;
  logic             is_shift;

  always_comb begin
    imm_i    = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
    imm_s    = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
    imm_b    = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    imm_u    = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
    imm_j    = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    imm_sh5  = {{(XLEN-5){1'b0}}, in_inst[24:20]};
    imm_sh6  = {{(XLEN-6){1'b0}}, in_inst[25:20]};
    funct3   = in_inst[14:12];
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (in_inst[6:0])
      7'b0000011, 7'b1100111: begin
        dec_imm = imm_i;
        dec_fmt = FMT_I;
      end
      7'b0010011: begin
        if (is_shift) begin
          dec_imm = (XLEN == 64) ? imm_sh6 : imm_sh5;
          dec_fmt = FMT_SHAMT;
        end else begin
          dec_imm = imm_i;
          dec_fmt = FMT_I;
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_imm = is_shift ? imm_sh5 : imm_i;
          dec_fmt = is_shift ? FMT_SHAMT : FMT_I;
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_imm = imm_s;
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        dec_imm = imm_b;
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = imm_u;
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        dec_imm = imm_j;
        dec_fmt = FMT_J;
      end
      7'b0110011, 7'b0001111, 7'b1110011: ;
      7'b0111011: dec_ill = (XLEN != 64);
      default:    dec_ill = 1'b1;
    endcase
  end

  // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
  logic [XLEN-1:0]  imm_q [2];
  logic [XLEN-1:0]  imm_d [2];
  logic [2:0]       fmt_q [2];
  logic [2:0]       fmt_d [2];
  logic             ill_q [2];
  logic             ill_d [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             push, pop, wr_idx;

  always_comb begin
    in_ready  = !reset && (count_q < 2'd2);
    out_valid = (count_q != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    imm_d     = imm_q;
    fmt_d     = fmt_q;
    ill_d     = ill_q;
    tag_d     = tag_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;

    if (pop) begin
      imm_d[0] = imm_q[1];
      fmt_d[0] = fmt_q[1];
      ill_d[0] = ill_q[1];
      tag_d[0] = tag_q[1];
    end
    wr_idx = (count_q == 2'd1) && !pop;
    if (push) begin
      imm_d[wr_idx] = dec_imm;
      fmt_d[wr_idx] = dec_fmt;
      ill_d[wr_idx] = dec_ill;
      tag_d[wr_idx] = in_tag;
      if (dec_ill && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= '0;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      ill_q     <= ill_d;
      tag_q     <= tag_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign out_imm       = imm_q[0];
  assign out_fmt       = fmt_q[0];
  assign out_illegal   = ill_q[0];
  assign out_tag       = tag_q[0];
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives XLEN=32 and XLEN=64 instances with identical traffic and checks both
// against a queue-based reference model every cycle.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [31:0] inst = '0;
  logic [4:0]  tag = '0;
  logic        ordy = 1'b0;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [4:0]  tag32;
  logic [15:0] ic32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [4:0]  tag64;
  logic [15:0] ic64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut32 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy32), .in_inst(inst), .in_tag(tag),
    .out_valid(ov32), .out_ready(ordy), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .out_tag(tag32), .illegal_count(ic32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(16)) dut64 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy64), .in_inst(inst), .in_tag(tag),
    .out_valid(ov64), .out_ready(ordy), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_tag(tag64), .illegal_count(ic64));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // Reference decode: immediates as signed integers, truncated per XLEN at compare time.
  function automatic void ref_decode(input logic [31:0] i, input bit x64,
                                     output logic [63:0] imm, output int fmt, output bit ill);
    logic [2:0] f3;
    bit sh;
    longint v;
    f3 = i[14:12];
    sh = (f3 == 3'd1) || (f3 == 3'd5);
    v = 0; fmt = 0; ill = 0;
    case (i[6:0])
      7'h03, 7'h67: begin v = longint'($signed(i[31:20])); fmt = 1; end
      7'h13: if (sh) begin v = x64 ? longint'(i[25:20]) : longint'(i[24:20]); fmt = 2; end
             else begin v = longint'($signed(i[31:20])); fmt = 1; end
      7'h1B: if (!x64) ill = 1;
             else if (sh) begin v = longint'(i[24:20]); fmt = 2; end
             else begin v = longint'($signed(i[31:20])); fmt = 1; end
      7'h23: begin v = longint'($signed({i[31:25], i[11:7]})); fmt = 3; end
      7'h63: begin v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); fmt = 4; end
      7'h37, 7'h17: begin v = longint'($signed({i[31:12], 12'h000})); fmt = 5; end
      7'h6F: begin v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); fmt = 6; end
      7'h33, 7'h0F, 7'h73: ;
      7'h3B: ill = !x64;
      default: ill = 1;
    endcase
    imm = x64 ? v : {32'h0, v[31:0]};
  endfunction

  typedef struct { logic [31:0] inst; logic [4:0] tag; } ent_t;
  ent_t        q[$];
  logic [15:0] m_ic32 = '0, m_ic64 = '0;
  bit          chk_en = 0;
  bit          last_push = 0;

  // Model update on each active edge from the bench's own input values.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ic32 = '0; m_ic64 = '0;
      last_push = 0;
      chk_en = 1;
    end else begin
      logic [63:0] di; int df; bit dl;
      bit push, pop;
      push = iv && (q.size() < 2);
      pop  = (q.size() > 0) && ordy;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{inst, tag});
        ref_decode(inst, 0, di, df, dl);
        if (dl && m_ic32 != 16'hFFFF) m_ic32++;
        ref_decode(inst, 1, di, df, dl);
        if (dl && m_ic64 != 16'hFFFF) m_ic64++;
      end
      last_push = push;
    end
  end

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] ei; int ef; bit el; bit erdy; bit ev;
      erdy = !rst && (q.size() < 2);
      ev   = (q.size() != 0);
      chk("in_ready32", rdy32, erdy);
      chk("in_ready64", rdy64, erdy);
      chk("out_valid32", ov32, ev);
      chk("out_valid64", ov64, ev);
      if (ev) begin
        ref_decode(q[0].inst, 0, ei, ef, el);
        chk("imm32", {32'h0, imm32}, ei);
        chk("fmt32", fmt32, ef);
        chk("illegal32", ill32, el);
        chk("tag32", tag32, q[0].tag);
        ref_decode(q[0].inst, 1, ei, ef, el);
        chk("imm64", imm64, ei);
        chk("fmt64", fmt64, ef);
        chk("illegal64", ill64, el);
        chk("tag64", tag64, q[0].tag);
      end
      chk("illegal_count32", ic32, m_ic32);
      chk("illegal_count64", ic64, m_ic64);
    end
  end

  task automatic sync();
    @(negedge clk); #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [4:0] tg);
    bit ok;
    iv = 1; inst = ins; tag = tg;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (last_push) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL offer_timeout inst=%h tag=%0d", ins, tg);
    end
    iv = 0;
  endtask

  logic [31:0] dir_inst [10] = '{32'hFFF00093, 32'h01F09093, 32'h4010D093, 32'hFE000EE3,
                                 32'h001000EF, 32'h800000B7, 32'h03F09093, 32'h03F0909B,
                                 32'h0000007F, 32'h0000007F};
  logic [6:0]  ops [16] = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F, 7'h00};

  initial begin
    logic [63:0] pi; int pf; bit pl;

    // Pin the reference model against hand-computed values.
    ref_decode(32'hFFF00093, 0, pi, pf, pl); chk("pin_addi", {pi, 32'(pf)}, {64'hFFFFFFFF, 32'd1});
    ref_decode(32'h01F09093, 0, pi, pf, pl); chk("pin_slli", {pi, 32'(pf)}, {64'h1F, 32'd2});
    ref_decode(32'h4010D093, 0, pi, pf, pl); chk("pin_srai", {pi, 32'(pf)}, {64'h1, 32'd2});
    ref_decode(32'hFE000EE3, 0, pi, pf, pl); chk("pin_beq", {pi, 32'(pf)}, {64'hFFFFFFFC, 32'd4});
    ref_decode(32'h001000EF, 0, pi, pf, pl); chk("pin_jal", {pi, 32'(pf)}, {64'h800, 32'd6});
    ref_decode(32'h800000B7, 1, pi, pf, pl); chk("pin_lui64", pi, 64'hFFFFFFFF80000000);
    ref_decode(32'h03F09093, 1, pi, pf, pl); chk("pin_slli64", pi, 64'h3F);
    ref_decode(32'h03F0909B, 1, pi, pf, pl); chk("pin_slliw64", {pi, 32'(pf)}, {64'h1F, 32'd2});
    ref_decode(32'h03F0909B, 0, pi, pf, pl); chk("pin_slliw32_ill", pl, 1);
    ref_decode(32'h0000007F, 1, pi, pf, pl); chk("pin_7f_ill", {pi, 31'(pf), pl}, {64'h0, 32'h1});

    ordy = 1;
    repeat (3) sync();
    rst = 0;
    sync();
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_fmt_tag", {fmt64, tag64, ill64}, '0);
    chk("rst_count", ic64, 16'h0);

    foreach (dir_inst[k]) offer(dir_inst[k], 5'(k + 3));
    repeat (3) sync();
    chk("dir_ic64", ic64, 16'd2);
    chk("dir_ic32", ic32, 16'd3);

    // Backpressure: two accepted, third stalls with head held.
    ordy = 0;
    offer(32'h00100093, 5'd1);
    offer(32'h00200093, 5'd2);
    iv = 1; inst = 32'h00300093; tag = 5'd3;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", rdy32, 0);
      chk("full_head_tag", tag32, 5'd1);
    end
    #1 ordy = 1;
    offer(32'h00300093, 5'd3);
    repeat (4) sync();

    // Reset mid-stream with a full buffer and a non-zero counter.
    ordy = 0;
    offer(32'h0000007F, 5'd7);
    offer(32'h0000007F, 5'd8);
    sync();
    rst = 1; iv = 1;
    @(negedge clk);
    chk("mid_rst_valid", ov32, 0);
    chk("mid_rst_ic", ic32, 16'h0);
    chk("mid_rst_tag", tag32, 5'h0);
    #1 rst = 0; iv = 0; ordy = 1;
    sync();

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r = $urandom;
      rst  = ($urandom_range(0, 299) == 0);
      iv   = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 9) < 7;
      inst = {r[31:7], ops[$urandom_range(0, 15)]};
      if (inst[6:0] == 7'h00) inst[6:0] = 7'($urandom);
      tag  = 5'($urandom);
      sync();
    end
    rst = 0; iv = 0; ordy = 1;
    repeat (4) sync();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes every base-ISA immediate format (I, shift-amount, S, B, U, J) sign-extended to XLEN. It flags unknown opcodes and counts them. A 2-entry output buffer absorbs execute-stage backpressure without dropping or duplicating instructions.

## Interface
Parameters:
- XLEN, 32 — datapath width; legal values 32 or 64.
- TAG_W, 5 — width of the sideband tag carried alongside each instruction (e.g. PC index or ROB id).
- CNT_W, 16 — width of the illegal-opcode counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  decoded entry available at the buffer head.
- out_ready  in  1  downstream consumes; pop when out_valid && out_ready.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 SHAMT, 3 S, 4 B, 5 U, 6 J.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the head entry.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode is combinational on in_inst. The result is written into the buffer on acceptance.
- Sign extension always comes from inst[31] to XLEN, except for SHAMT (zero-extended).
- Opcode decode:
  - 0000011 (load), 1100111 (JALR): I-type, imm = sext(inst[31:20]).
  - 0010011 (OP-IMM):
    - funct3 001/101: SHAMT, imm = zext(inst[24:20]) when XLEN=32, zext(inst[25:20]) when XLEN=64. The funct7 bits (e.g. bit30 for SRAI) are excluded.
    - Otherwise: I-type.
  - 0011011 (OP-IMM-32): legal only when XLEN=64. Same as OP-IMM, but SHAMT always uses inst[24:20]. When XLEN=32 it is illegal.
  - 0100011: S, imm = sext({inst[31:25], inst[11:7]}).
  - 1100011: B, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 (LUI), 0010111 (AUIPC): U, imm = sext({inst[31:12], 12'b0}).
  - 1101111: J, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0110011, 0111011 (XLEN=64 only), 0001111, 1110011: legal, fmt NONE, imm 0.
  - Anything else: out_illegal=1, fmt NONE, imm 0.
- Buffer:
  - 2-entry FIFO with a count register (0..2).
  - in_ready = !reset && (count < 2). in_ready depends only on registered state, never on out_ready.
  - Push and pop in the same cycle leave count unchanged and preserve order.
  - out_valid = (count != 0). Head fields are held stable while out_valid && !out_ready.
- illegal_count:
  - Increments on each accepted instruction whose decode is illegal.
  - Saturates at all-ones.
  - Is not decremented by pops.

## Timing
- Latency: an instruction accepted at edge N appears on out_* after edge N (valid in cycle N+1) when the buffer was empty.
- Throughput: 1 instruction/cycle with out_ready held high. With count=1 and out_ready=1, the buffer sustains push+pop every cycle.
- Full: count=2 forces in_ready=0. A pop in that cycle re-asserts in_ready the following cycle.
- Reset (synchronous, any cycle, including mid-stream):
  - Next edge sets count=0, out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_count=0.
  - in_ready=0 while reset is high. Buffered entries are discarded.
  - in_valid asserted during reset is ignored.
- Empty: out_valid=0. out_ready is ignored and count never underflows.

## Test plan
- ADDI 0xFFF00093, tag 3, out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt=1, tag=3, illegal=0.
- SLLI 0x01F09093 then SRAI 0x4010D093, back-to-back → imm 0x0000001F then 0x00000001, both fmt=2, consecutive cycles.
- BEQ 0xFE000EE3 → imm 0xFFFFFFFC fmt=4; JAL 0x001000EF → imm 0x00000800 fmt=6.
- out_ready=0, offer 3 instructions (tags 1,2,3) → in_ready low after 2 accepts, head holds tag 1 stable; out_ready=1 → tags 1,2,3 emerge in order, none lost or duplicated.
- XLEN=64: LUI 0x800000B7 → imm 0xFFFFFFFF80000000; SLLI 0x03F09093 → imm 0x3F; OP-IMM-32 SLLIW 0x03F0909B → imm 0x1F.
- Opcode 0x0000007F twice → illegal=1, imm 0, illegal_count=2; assert reset mid-stream with count=2 → out_valid=0, illegal_count=0 the next cycle.
